circuito_exp5: RTL and testbench

CIRCUITO_EXP5 -- requirements
Module: circuito_exp5

---
 rtl/circuito_exp5.sv | 221 ++++++++++++++++++++++
 tb/tb_circuito_exp5.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/circuito_exp5.sv
`timescale 1ns/1ps
// circuito_exp5 -- memory game. The player repeats a growing sequence that is
// stored in a 16x4 ROM. Round r asks for ROM words 0..r. The game is won after
// round 7 in easy mode or after round 15 in hard mode. A wrong press loses the
// game.
//
// Optional feature (macro TIMEOUT_EN): a 5000-cycle inactivity timer runs while
// the FSM waits for a press. If it expires, the game ends in fim_timeout.
//
// Ports:
//   clock, reset            system clock; asynchronous active-high reset
//   iniciar                 start/restart request, level-sampled
//   botoes[3:0]             player buttons, one-hot when pressed
//   botaoDificuldade        0 = easy (8 rounds), 1 = hard (16 rounds)
//   acertou/errou/pronto    game won / game lost / game finished (Moore)
//   leds[3:0]               registered play
//   db_* (7 bit)            active-low 7-segment codes, bit order gfedcba
//   db_* (1 bit)            comparator, clock, iniciar, press pulse, timeout,
//                           latched difficulty
module circuito_exp5 (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] botoes,
  input  logic       botaoDificuldade,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic [3:0] leds,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_limite,
  output logic       db_igual,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_tem_jogada,
  output logic       db_timeout,
  output logic       db_dificuldade
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    ESPERA_JOGADA  = 4'h2,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTOU    = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERROU      = 4'hE
  } estado_t;

  estado_t    state_q, state_d;
  logic [3:0] botoes_q;
  logic [3:0] contagem_q, contagem_d;
  logic [3:0] rodada_q, rodada_d;
  logic [3:0] jogada_q, jogada_d;
  logic       dific_q, dific_d;
  logic [3:0] rom_data;
  logic       tem_jogada;
  logic       igual;
  logic       timeout;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    case (contagem_q)
      4'd0:  rom_data = 4'h1;
      4'd1:  rom_data = 4'h2;
      4'd2:  rom_data = 4'h4;
      4'd3:  rom_data = 4'h8;
      4'd4:  rom_data = 4'h4;
      4'd5:  rom_data = 4'h2;
      4'd6:  rom_data = 4'h1;
      4'd7:  rom_data = 4'h1;
      4'd8:  rom_data = 4'h2;
      4'd9:  rom_data = 4'h2;
      4'd10: rom_data = 4'h4;
      4'd11: rom_data = 4'h4;
      4'd12: rom_data = 4'h8;
      4'd13: rom_data = 4'h8;
      4'd14: rom_data = 4'h1;
      default: rom_data = 4'h4;
    endcase
  end

  // The press pulse is raised on the first cycle any button is down after a
  // cycle with all buttons released.
  assign tem_jogada = (|botoes) & ~(|botoes_q);
  assign igual      = (jogada_q == rom_data);

`ifdef TIMEOUT_EN
  logic [12:0] timer_q, timer_d;
  // The timer runs only in espera_jogada. It is held at zero in every other
  // state, so each entry into espera_jogada starts a fresh count.
  assign timer_d    = (state_q == ESPERA_JOGADA) ? timer_q + 13'd1 : '0;
  assign timeout    = (timer_q == 13'd4999);
  assign db_timeout = (state_q == FIM_TIMEOUT);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  assign timeout    = 1'b0;
  assign db_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= INICIAL;
      botoes_q   <= '0;
      contagem_q <= '0;
      rodada_q   <= '0;
      jogada_q   <= '0;
      dific_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      botoes_q   <= botoes;
      contagem_q <= contagem_d;
      rodada_q   <= rodada_d;
      jogada_q   <= jogada_d;
      dific_q    <= dific_d;
    end
  end

  // Datapath updates, selected by the current state.
  always_comb begin
    contagem_d = contagem_q;
    rodada_d   = rodada_q;
    jogada_d   = jogada_q;
    dific_d    = dific_q;
    case (state_q)
      PREPARACAO: begin
        contagem_d = '0;
        rodada_d   = '0;
        jogada_d   = '0;
        dific_d    = botaoDificuldade;
      end
      REGISTRA:       jogada_d   = botoes;
      PROXIMA_JOGADA: contagem_d = contagem_q + 4'd1;
      PROXIMA_RODADA: begin
        rodada_d   = rodada_q + 4'd1;
        contagem_d = '0;
      end
      default: ;
    endcase
  end

  // Next-state logic and the Moore outputs.
  always_comb begin
    state_d = state_q;
    acertou = 1'b0;
    errou   = 1'b0;
    pronto  = 1'b0;
    case (state_q)
      INICIAL:        if (iniciar) state_d = PREPARACAO;
      PREPARACAO:     state_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (tem_jogada)   state_d = REGISTRA;
        else if (timeout) state_d = FIM_TIMEOUT;
      end
      REGISTRA:       state_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)                      state_d = FIM_ERROU;
        else if (contagem_q != rodada_q) state_d = PROXIMA_JOGADA;
        else if (rodada_q == (dific_q ? 4'd15 : 4'd7)) state_d = FIM_ACERTOU;
        else                             state_d = PROXIMA_RODADA;
      end
      PROXIMA_JOGADA: state_d = ESPERA_JOGADA;
      PROXIMA_RODADA: state_d = ESPERA_JOGADA;
      FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
        if (iniciar) state_d = PREPARACAO;
      end
      FIM_ERROU, FIM_TIMEOUT: begin
        pronto = 1'b1;
        errou  = 1'b1;
        if (iniciar) state_d = PREPARACAO;
      end
      default: state_d = INICIAL;
    endcase
  end

  assign leds           = jogada_q;
  assign db_contagem    = hex7(contagem_q);
  // ROM word 0 is nonzero. The display is held at "0" while idle, so the
  // reset state shows a uniform "0" on every 7-segment output.
  assign db_memoria     = hex7((state_q == INICIAL) ? 4'h0 : rom_data);
  assign db_estado      = hex7(state_q);
  assign db_jogadafeita = hex7(jogada_q);
  assign db_limite      = hex7(rodada_q);
  assign db_igual       = igual;
  assign db_clock       = clock;
  assign db_iniciar     = iniciar;
  assign db_tem_jogada  = tem_jogada;
  assign db_dificuldade = dific_q;

endmodule

// File: tb/tb_circuito_exp5.sv
`timescale 1ns/1ps
module tb_circuito_exp5;

  logic       clock = 1'b0;
  logic       reset, iniciar, botaoDificuldade;
  logic [3:0] botoes;
  logic       acertou, errou, pronto;
  logic [3:0] leds;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_limite;
  logic       db_igual, db_clock, db_iniciar, db_tem_jogada, db_timeout, db_dificuldade;

  int checks   = 0;
  int failures = 0;

  logic [3:0] rom [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                           4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

  circuito_exp5 dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
    .botaoDificuldade(botaoDificuldade),
    .acertou(acertou), .errou(errou), .pronto(pronto), .leds(leds),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_estado(db_estado),
    .db_jogadafeita(db_jogadafeita), .db_limite(db_limite),
    .db_igual(db_igual), .db_clock(db_clock), .db_iniciar(db_iniciar),
    .db_tem_jogada(db_tem_jogada), .db_timeout(db_timeout),
    .db_dificuldade(db_dificuldade)
  );

  always #5 clock = ~clock;

  // Active-low gfedcba codes for hex digits.
  function automatic logic [6:0] seg(input int v);
    case (v)
      0: seg = 7'h40;  1: seg = 7'h79;  2: seg = 7'h24;  3: seg = 7'h30;
      4: seg = 7'h19;  5: seg = 7'h12;  6: seg = 7'h02;  7: seg = 7'h78;
      8: seg = 7'h00;  9: seg = 7'h10;  10: seg = 7'h08; 11: seg = 7'h03;
      12: seg = 7'h46; 13: seg = 7'h21; 14: seg = 7'h06; default: seg = 7'h0E;
    endcase
  endfunction

  task automatic press(input logic [3:0] v);
    botoes = v;
    repeat (10) @(negedge clock);
    botoes = '0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (db_estado !== seg(0)) begin failures++; $display("FAIL reset_estado got=%h exp=%h", db_estado, seg(0)); end
    checks++; if ({acertou, errou, pronto} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {acertou, errou, pronto}); end
    checks++; if (leds !== 4'h0) begin failures++; $display("FAIL reset_leds got=%h exp=0", leds); end
    checks++; if ({db_contagem, db_memoria, db_jogadafeita, db_limite} !== {4{seg(0)}}) begin failures++;
      $display("FAIL reset_7seg got=%h %h %h %h exp=%h", db_contagem, db_memoria, db_jogadafeita, db_limite, seg(0)); end
    checks++; if ({db_igual, db_tem_jogada, db_timeout, db_dificuldade} !== 4'b0000) begin failures++;
      $display("FAIL reset_dbg got=%b exp=0000", {db_igual, db_tem_jogada, db_timeout, db_dificuldade}); end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (db_estado !== seg(0)) begin failures++; $display("FAIL idle_estado got=%h exp=%h", db_estado, seg(0)); end
  endtask

  task automatic test_easy_win;
    botaoDificuldade = 1'b0;
    iniciar = 1'b1;
    repeat (5) @(negedge clock);
    iniciar = 1'b0;
    checks++; if (db_estado !== seg(2) || db_dificuldade !== 1'b0) begin failures++;
      $display("FAIL easy_start got=%h/%b exp=%h/0", db_estado, db_dificuldade, seg(2)); end
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i <= r; i++) press(rom[i]);
      if (r < 7) begin
        checks++; if (db_estado !== seg(2) || db_limite !== seg(r + 1) || pronto !== 1'b0) begin failures++;
          $display("FAIL easy_round%0d got=%h/%h/%b exp=%h/%h/0", r, db_estado, db_limite, pronto, seg(2), seg(r + 1)); end
      end else begin
        checks++; if (db_estado !== seg(10)) begin failures++; $display("FAIL easy_fim_estado got=%h exp=%h", db_estado, seg(10)); end
        checks++; if ({acertou, errou, pronto} !== 3'b101) begin failures++; $display("FAIL easy_fim_flags got=%b exp=101", {acertou, errou, pronto}); end
        checks++; if (leds !== 4'h1 || db_igual !== 1'b1) begin failures++; $display("FAIL easy_fim_leds got=%h/%b exp=1/1", leds, db_igual); end
      end
    end
  endtask

  task automatic test_restart_from_fim;
    iniciar = 1'b1;
    @(negedge clock);
    checks++; if (db_estado !== seg(1)) begin failures++; $display("FAIL restart_prep got=%h exp=%h", db_estado, seg(1)); end
    @(negedge clock);
    checks++; if (db_estado !== seg(2) || db_contagem !== seg(0) || db_limite !== seg(0) || leds !== 4'h0) begin failures++;
      $display("FAIL restart_clear got=%h/%h/%h/%h", db_estado, db_contagem, db_limite, leds); end
    checks++; if (db_memoria !== seg(1) || acertou !== 1'b0) begin failures++; $display("FAIL restart_mem got=%h/%b exp=%h/0", db_memoria, acertou, seg(1)); end
    repeat (3) @(negedge clock);
    iniciar = 1'b0;
    checks++; if (db_estado !== seg(2)) begin failures++; $display("FAIL iniciar_ignored got=%h exp=%h", db_estado, seg(2)); end
  endtask

  task automatic test_error;
    press(4'h1);
    checks++; if (db_limite !== seg(1) || db_estado !== seg(2)) begin failures++; $display("FAIL err_round0 got=%h/%h", db_limite, db_estado); end
    press(4'h1);
    checks++; if (db_contagem !== seg(1)) begin failures++; $display("FAIL err_next_play got=%h exp=%h", db_contagem, seg(1)); end
    press(4'h4);
    checks++; if (db_estado !== seg(14)) begin failures++; $display("FAIL err_estado got=%h exp=%h", db_estado, seg(14)); end
    checks++; if ({acertou, errou, pronto} !== 3'b011 || leds !== 4'h4) begin failures++;
      $display("FAIL err_flags got=%b/%h exp=011/4", {acertou, errou, pronto}, leds); end
    press(4'h8);
    checks++; if (db_estado !== seg(14) || leds !== 4'h4) begin failures++; $display("FAIL fim_press_ignored got=%h/%h", db_estado, leds); end
  endtask

  task automatic test_hard_win;
    botaoDificuldade = 1'b1;
    iniciar = 1'b1;
    repeat (5) @(negedge clock);
    iniciar = 1'b0;
    botaoDificuldade = 1'b0;
    checks++; if (db_dificuldade !== 1'b1 || db_estado !== seg(2)) begin failures++;
      $display("FAIL hard_start got=%b/%h exp=1/%h", db_dificuldade, db_estado, seg(2)); end
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i <= r; i++) begin
        if (r == 7 && i == 7) begin
          botoes = rom[i];
          repeat (3) @(negedge clock);
          checks++; if (db_estado !== seg(7) || pronto !== 1'b0) begin failures++;
            $display("FAIL hard_round7_state got=%h/%b exp=%h/0", db_estado, pronto, seg(7)); end
          repeat (7) @(negedge clock);
          botoes = '0;
          repeat (10) @(negedge clock);
        end else begin
          press(rom[i]);
        end
      end
      if (r < 15) begin
        checks++; if (acertou !== 1'b0 || db_estado !== seg(2)) begin failures++;
          $display("FAIL hard_round%0d got=%b/%h exp=0/%h", r, acertou, db_estado, seg(2)); end
      end else begin
        checks++; if (db_estado !== seg(10) || {acertou, errou, pronto} !== 3'b101) begin failures++;
          $display("FAIL hard_fim got=%h/%b exp=%h/101", db_estado, {acertou, errou, pronto}, seg(10)); end
      end
    end
  endtask

  task automatic test_midround_reset;
    botaoDificuldade = 1'b1;
    iniciar = 1'b1;
    repeat (2) @(negedge clock);
    iniciar = 1'b0;
    press(4'h1);
    press(4'h1);
    checks++; if (db_contagem !== seg(1) || leds !== 4'h1 || db_dificuldade !== 1'b1) begin failures++;
      $display("FAIL mid_before got=%h/%h/%b", db_contagem, leds, db_dificuldade); end
    #2 reset = 1'b1;
    #1;
    checks++; if (db_estado !== seg(0) || leds !== 4'h0 || db_dificuldade !== 1'b0) begin failures++;
      $display("FAIL mid_reset got=%h/%h/%b exp=%h/0/0", db_estado, leds, db_dificuldade, seg(0)); end
    checks++; if ({db_contagem, db_limite, db_memoria, db_jogadafeita} !== {4{seg(0)}} || pronto !== 1'b0) begin failures++;
      $display("FAIL mid_reset_7seg got=%h %h %h %h", db_contagem, db_limite, db_memoria, db_jogadafeita); end
    @(negedge clock);
    reset = 1'b0;
    botaoDificuldade = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_timeout;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
`ifdef TIMEOUT_EN
    repeat (4999) @(negedge clock);
    checks++; if (db_estado !== seg(2)) begin failures++; $display("FAIL timeout_early got=%h exp=%h", db_estado, seg(2)); end
    @(negedge clock);
    checks++; if (db_estado !== seg(13) || errou !== 1'b1 || pronto !== 1'b1 || db_timeout !== 1'b1) begin failures++;
      $display("FAIL timeout_fim got=%h/%b/%b/%b exp=%h/1/1/1", db_estado, errou, pronto, db_timeout, seg(13)); end
`else
    repeat (5100) @(negedge clock);
    checks++; if (db_estado !== seg(2) || db_timeout !== 1'b0 || errou !== 1'b0) begin failures++;
      $display("FAIL no_timeout got=%h/%b/%b exp=%h/0/0", db_estado, db_timeout, errou, seg(2)); end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    iniciar = 1'b0;
    botoes = '0;
    botaoDificuldade = 1'b0;
    test_reset();
    test_easy_win();
    test_restart_from_fim();
    test_error();
    test_hard_win();
    test_midround_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
